bp_commit_trace_arbiter: RTL

BP_COMMIT_TRACE_ARBITER -- requirements
Module: bp_commit_trace_arbiter

---
 rtl/bp_common_pkg.sv | 32 +++
 rtl/bp_commit_trace_fifo.sv | 67 ++++++
 rtl/bp_commit_trace_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/bp_common_pkg.sv
// ============================================================================
//  Module      : bp_common_pkg
//  Description : Shared constants, commit-trace record declaration macro and
//                output-stage state encoding for the commit trace arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Declares the packed commit record type inside a parameterised module.
`define BP_COMMIT_TRACE_REC_S(vaddr_w, instr_w, dword_w) \
  typedef struct packed { \
    logic [vaddr_w-1:0]                          pc; \
    logic [instr_w-1:0]                          instr; \
    logic                                        rd_w_v; \
    logic [bp_common_pkg::rd_addr_width_gp-1:0]  rd_addr; \
    logic [dword_w-1:0]                          rd_data; \
    logic [bp_common_pkg::itag_width_gp-1:0]     itag; \
  } bp_commit_trace_rec_s

package bp_common_pkg;

  localparam int itag_width_gp    = 31;
  localparam int rd_addr_width_gp = 5;

  typedef enum logic [0:0] {
    e_trace_out_empty = 1'b0,
    e_trace_out_full  = 1'b1
  } bp_trace_out_state_e;

endpackage

`default_nettype wire

// File: rtl/bp_commit_trace_fifo.sv
// ============================================================================
//  Module      : bp_commit_trace_fifo
//  Description : Per-core commit record buffer. Power-of-two depth, extra
//                pointer bit for full/empty, accepts a push while full when
//                the same cycle pops.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_commit_trace_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_width_lp = $clog2(els_p);

  logic [ptr_width_lp:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [els_p-1:0][width_p-1:0] mem_q, mem_d;
  logic                          push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[ptr_width_lp] != rptr_q[ptr_width_lp]) &&
                   (wptr_q[ptr_width_lp-1:0] == rptr_q[ptr_width_lp-1:0]);
  assign pop_ok  = pop_i & ~empty_o;
  // A full buffer frees the head slot this cycle when popped, so the write may land there.
  assign push_ok = push_i & (~full_o | pop_ok);
  assign data_o  = mem_q[rptr_q[ptr_width_lp-1:0]];

  // Next pointers and storage contents.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (push_ok) begin
      mem_d[wptr_q[ptr_width_lp-1:0]] = data_i;
      wptr_d = wptr_q + (ptr_width_lp+1)'(1);
    end
    if (pop_ok) begin
      rptr_d = rptr_q + (ptr_width_lp+1)'(1);
    end
  end

  // Buffer state registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bp_commit_trace_arbiter.sv
// ============================================================================
//  Module      : bp_commit_trace_arbiter
//  Description : Captures per-core commit records into per-core buffers and
//                merges them round-robin onto one valid/ready trace port.
//                Optional feature macro BP_COMMIT_TRACE_DROP_CNT_EN adds
//                per-core 16-bit saturating drop counters on drop_cnt_o.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_commit_trace_arbiter
  import bp_common_pkg::*;
#(
  parameter int num_core_p    = 2,
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int dword_width_p = 64,
  parameter int fifo_els_p    = 4,
  localparam int hart_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              en_i,
  input  logic [num_core_p-1:0]             commit_v_i,
  input  logic [num_core_p*vaddr_width_p-1:0] commit_pc_i,
  input  logic [num_core_p*instr_width_p-1:0] commit_instr_i,
  input  logic [num_core_p-1:0]             rd_w_v_i,
  input  logic [num_core_p*5-1:0]           rd_addr_i,
  input  logic [num_core_p*dword_width_p-1:0] rd_data_i,
  output logic                              trace_v_o,
  input  logic                              trace_ready_i,
  output logic [hart_width_lp-1:0]          trace_hartid_o,
  output logic [vaddr_width_p-1:0]          trace_pc_o,
  output logic [instr_width_p-1:0]          trace_instr_o,
  output logic [itag_width_gp-1:0]          trace_itag_o,
  output logic                              trace_rd_w_v_o,
  output logic [4:0]                        trace_rd_addr_o,
  output logic [dword_width_p-1:0]          trace_rd_data_o
`ifdef BP_COMMIT_TRACE_DROP_CNT_EN
  , output logic [num_core_p*16-1:0]        drop_cnt_o
`endif
);

  `BP_COMMIT_TRACE_REC_S(vaddr_width_p, instr_width_p, dword_width_p);

  localparam int rec_width_lp = $bits(bp_commit_trace_rec_s);

  logic [num_core_p-1:0]                   commit_take;
  logic [num_core_p-1:0]                   fifo_full, fifo_empty, fifo_pop;
  logic [num_core_p-1:0][rec_width_lp-1:0] fifo_rdata;
  logic                                    grant_v, can_load;
  logic [hart_width_lp-1:0]                grant_idx;
  bp_trace_out_state_e                     state_q, state_d;
  logic [hart_width_lp-1:0]                rr_q, rr_d, hart_q, hart_d;
  bp_commit_trace_rec_s                    out_q, out_d;

  // Commits are only seen while capture is enabled; buffered records still drain.
  assign commit_take = commit_v_i & {num_core_p{en_i}};
  // The output register can take a new record when empty or when it is being consumed.
  assign can_load    = (state_q == e_trace_out_empty) | trace_ready_i;

  for (genvar c = 0; c < num_core_p; c++) begin : g_core
    logic [itag_width_gp-1:0] itag_q, itag_d;
    bp_commit_trace_rec_s     push_rec;

    // Tag advances on every enabled commit, including ones that get dropped.
    always_comb begin
      itag_d = itag_q;
      if (commit_take[c]) begin
        itag_d = itag_q + itag_width_gp'(1);
      end
    end

    // Per-core tag counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        itag_q <= '0;
      end else begin
        itag_q <= itag_d;
      end
    end

    // Assemble the record from this core's slice of the commit bus.
    always_comb begin
      push_rec         = '0;
      push_rec.pc      = commit_pc_i[c*vaddr_width_p +: vaddr_width_p];
      push_rec.instr   = commit_instr_i[c*instr_width_p +: instr_width_p];
      push_rec.rd_w_v  = rd_w_v_i[c];
      push_rec.rd_addr = rd_addr_i[c*5 +: 5];
      push_rec.rd_data = rd_data_i[c*dword_width_p +: dword_width_p];
      push_rec.itag    = itag_q;
    end

    assign fifo_pop[c] = grant_v & can_load & (grant_idx == hart_width_lp'(c));

    bp_commit_trace_fifo #(
      .width_p (rec_width_lp),
      .els_p   (fifo_els_p)
    ) u_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .push_i    (commit_take[c]),
      .pop_i     (fifo_pop[c]),
      .data_i    (push_rec),
      .data_o    (fifo_rdata[c]),
      .full_o    (fifo_full[c]),
      .empty_o   (fifo_empty[c])
    );

`ifdef BP_COMMIT_TRACE_DROP_CNT_EN
    logic        drop;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign drop = commit_take[c] & fifo_full[c] & ~fifo_pop[c];

    // Saturating count of records lost to a full buffer.
    always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end

    // Drop counter register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        drop_cnt_q <= '0;
      end else begin
        drop_cnt_q <= drop_cnt_d;
      end
    end

    assign drop_cnt_o[c*16 +: 16] = drop_cnt_q;
`endif
  end

  // Round-robin search for the first non-empty buffer at or after the rr pointer.
  always_comb begin
    int idx;
    idx       = 0;
    grant_v   = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < num_core_p; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= num_core_p) begin
        idx = idx - num_core_p;
      end
      if (!grant_v && !fifo_empty[idx]) begin
        grant_v   = 1'b1;
        grant_idx = hart_width_lp'(idx);
      end
    end
  end

  // Output stage next state: load on grant, go empty when consumed without a refill.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    hart_d  = hart_q;
    rr_d    = rr_q;
    case (state_q)
      e_trace_out_empty: if (grant_v) state_d = e_trace_out_full;
      e_trace_out_full:  if (trace_ready_i) state_d = grant_v ? e_trace_out_full : e_trace_out_empty;
      default:           state_d = e_trace_out_empty;
    endcase
    if (grant_v && can_load) begin
      out_d  = bp_commit_trace_rec_s'(fifo_rdata[grant_idx]);
      hart_d = grant_idx;
      rr_d   = (grant_idx == hart_width_lp'(num_core_p - 1)) ? '0 : grant_idx + hart_width_lp'(1);
    end
  end

  // Output stage and arbitration pointer registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_trace_out_empty;
      out_q   <= '0;
      hart_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      hart_q  <= hart_d;
      rr_q    <= rr_d;
    end
  end

  assign trace_v_o       = (state_q == e_trace_out_full);
  assign trace_hartid_o  = hart_q;
  assign trace_pc_o      = out_q.pc;
  assign trace_instr_o   = out_q.instr;
  assign trace_itag_o    = out_q.itag;
  assign trace_rd_w_v_o  = out_q.rd_w_v;
  assign trace_rd_addr_o = out_q.rd_addr;
  assign trace_rd_data_o = out_q.rd_data;

endmodule

`default_nettype wire
